// File: rtl/uart_program_loader.sv
// UART program loader: 8N1 receiver plus frame parser that writes a program image
// into 16-bit program memory and holds the CPU in reset while loading.
module uart_program_loader #(
  parameter int unsigned ClksPerBit  = 217,
  parameter int unsigned NumWords    = 4096,
  parameter int unsigned TimeoutClks = 250000
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        rx,
  output logic        progWriteEnable,
  output logic [15:0] progWriteAddr,
  output logic [15:0] progWriteData,
  output logic        cpuHold,
  output logic        loadDone,
  output logic        loadError
);

  localparam int unsigned CntW = $clog2(ClksPerBit + 1);
  localparam int unsigned ToW  = $clog2(TimeoutClks + 1);

  localparam logic [CntW-1:0] HalfBit  = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CntW-1:0] FullBit  = CntW'(ClksPerBit - 1);
  localparam logic [ToW-1:0]  ToLimit  = ToW'(TimeoutClks);
  localparam logic [16:0]     MaxLen   = 17'(NumWords);
  localparam logic [7:0]      SyncByte = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_LEN_HI,
    P_LEN_LO,
    P_DATA_HI,
    P_DATA_LO,
    P_CHECK,
    P_ERROR
  } p_state_t;

  // ---------------------------------------------------------------------------
  // Synchronizer; sync_age gates start detection until a real line sample exists
  // ---------------------------------------------------------------------------
  logic       rx_meta;
  logic       rx_sync;
  logic [1:0] sync_age;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      sync_age <= 2'd0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      if (!sync_age[1]) sync_age <= sync_age + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // 8N1 receiver
  // ---------------------------------------------------------------------------
  rx_state_t       rx_state, rx_state_d;
  logic [CntW-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [7:0]      shift, shift_d;
  logic            armed, armed_d;
  logic            byte_valid, byte_valid_d;
  logic            frame_err, frame_err_d;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      armed      <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      bit_idx    <= bit_idx_d;
      shift      <= shift_d;
      armed      <= armed_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  // armed means the previous idle sample was high, so a low sample is a falling edge
  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt;
    bit_idx_d    = bit_idx;
    shift_d      = shift;
    armed_d      = armed;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        armed_d = sync_age[1] & rx_sync;
        if (armed && !rx_sync) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          armed_d    = 1'b0;
        end
      end
      RX_START: begin
        if (rx_cnt == HalfBit) begin
          rx_cnt_d  = '0;
          bit_idx_d = '0;
          rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt + CntW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == FullBit) begin
          rx_cnt_d  = '0;
          shift_d   = {rx_sync, shift[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt + CntW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == FullBit) begin
          rx_cnt_d     = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_d = rx_sync;
          frame_err_d  = ~rx_sync;
        end else begin
          rx_cnt_d = rx_cnt + CntW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  p_state_t       p_state, p_state_d;
  logic [15:0]    len, len_d;
  logic [15:0]    addr, addr_d;
  logic [7:0]     hi_byte, hi_byte_d;
  logic [7:0]     chk, chk_d;
  logic [ToW-1:0] to_cnt, to_cnt_d;
  logic           we_d;
  logic [15:0]    waddr_d;
  logic [15:0]    wdata_d;
  logic           hold_d;
  logic           done_d;
  logic           err_d;
  logic [15:0]    len_word;
  logic           timeout_hit;

  assign len_word    = {len[15:8], shift};
  assign timeout_hit = (p_state != P_IDLE) && (to_cnt == ToLimit);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      p_state         <= P_IDLE;
      len             <= '0;
      addr            <= '0;
      hi_byte         <= '0;
      chk             <= '0;
      to_cnt          <= '0;
      progWriteEnable <= 1'b0;
      progWriteAddr   <= '0;
      progWriteData   <= '0;
      cpuHold         <= 1'b0;
      loadDone        <= 1'b0;
      loadError       <= 1'b0;
    end else begin
      p_state         <= p_state_d;
      len             <= len_d;
      addr            <= addr_d;
      hi_byte         <= hi_byte_d;
      chk             <= chk_d;
      to_cnt          <= to_cnt_d;
      progWriteEnable <= we_d;
      progWriteAddr   <= waddr_d;
      progWriteData   <= wdata_d;
      cpuHold         <= hold_d;
      loadDone        <= done_d;
      loadError       <= err_d;
    end
  end

  // Entry into ERROR raises loadError immediately; the ERROR state itself only
  // spends one cycle before returning to IDLE.
  always_comb begin
    p_state_d = p_state;
    len_d     = len;
    addr_d    = addr;
    hi_byte_d = hi_byte;
    chk_d     = chk;
    to_cnt_d  = to_cnt;
    we_d      = 1'b0;
    waddr_d   = progWriteAddr;
    wdata_d   = progWriteData;
    hold_d    = cpuHold;
    done_d    = loadDone;
    err_d     = loadError;

    if (byte_valid || (p_state == P_IDLE)) begin
      to_cnt_d = '0;
    end else if (to_cnt != ToLimit) begin
      to_cnt_d = to_cnt + ToW'(1);
    end

    case (p_state)
      P_IDLE: begin
        if (byte_valid && (shift == SyncByte)) begin
          p_state_d = P_LEN_HI;
          hold_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          chk_d     = '0;
          addr_d    = '0;
        end
      end
      P_ERROR: p_state_d = P_IDLE;
      default: begin
        if (frame_err || timeout_hit) begin
          p_state_d = P_ERROR;
          err_d     = 1'b1;
          hold_d    = 1'b1;
        end else if (byte_valid) begin
          case (p_state)
            P_LEN_HI: begin
              len_d     = {shift, len[7:0]};
              p_state_d = P_LEN_LO;
            end
            P_LEN_LO: begin
              len_d = len_word;
              if ((len_word == '0) || ({1'b0, len_word} > MaxLen)) begin
                p_state_d = P_ERROR;
                err_d     = 1'b1;
              end else begin
                p_state_d = P_DATA_HI;
              end
            end
            P_DATA_HI: begin
              hi_byte_d = shift;
              chk_d     = chk ^ shift;
              p_state_d = P_DATA_LO;
            end
            P_DATA_LO: begin
              we_d    = 1'b1;
              waddr_d = addr;
              wdata_d = {hi_byte, shift};
              chk_d   = chk ^ shift;
              if (addr == (len - 16'd1)) begin
                p_state_d = P_CHECK;
              end else begin
                addr_d    = addr + 16'd1;
                p_state_d = P_DATA_HI;
              end
            end
            P_CHECK: begin
              if (shift == chk) begin
                done_d    = 1'b1;
                hold_d    = 1'b0;
                p_state_d = P_IDLE;
              end else begin
                err_d     = 1'b1;
                p_state_d = P_ERROR;
              end
            end
            default: p_state_d = P_IDLE;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed frames plus random frames
// checked against a frame-level model of expected writes and status flags.
module tb_uart_program_loader;

  localparam int unsigned CPB = 8;
  localparam int unsigned TO  = 400;
  localparam int unsigned NW  = 4096;

  logic        clk = 1'b0;
  logic        rstN;
  logic        rx;
  logic        progWriteEnable;
  logic [15:0] progWriteAddr;
  logic [15:0] progWriteData;
  logic        cpuHold;
  logic        loadDone;
  logic        loadError;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] got_q[$];

  uart_program_loader #(
    .ClksPerBit (CPB),
    .NumWords   (NW),
    .TimeoutClks(TO)
  ) dut (
    .clk            (clk),
    .rstN           (rstN),
    .rx             (rx),
    .progWriteEnable(progWriteEnable),
    .progWriteAddr  (progWriteAddr),
    .progWriteData  (progWriteData),
    .cpuHold        (cpuHold),
    .loadDone       (loadDone),
    .loadError      (loadError)
  );

  always #5 clk = ~clk;

  // Every high strobe cycle is logged, so a stretched strobe shows up as an extra write
  always @(negedge clk) begin
    if (rstN && progWriteEnable) got_q.push_back({progWriteAddr, progWriteData});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
    idle(2 * CPB);
  endtask

  task automatic send_frame(input logic [7:0] bs[$]);
    foreach (bs[i]) send_byte(bs[i], 1'b1);
  endtask

  task automatic check_writes(input string tag, input logic [31:0] exp_q[$]);
    chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
  endtask

  task automatic check_flags(input string tag, input logic hold, input logic done,
                             input logic err);
    chk({tag, "_hold"}, 32'(cpuHold), 32'(hold));
    chk({tag, "_done"}, 32'(loadDone), 32'(done));
    chk({tag, "_err"}, 32'(loadError), 32'(err));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, 32'(progWriteEnable), 32'd0);
    chk({tag, "_addr"}, 32'(progWriteAddr), 32'd0);
    chk({tag, "_data"}, 32'(progWriteData), 32'd0);
    check_flags(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0]  fb[$];
    logic [31:0] ew[$];
    logic [7:0]  xs;
    int          n;
    logic [15:0] w;
    logic        corrupt;

    rstN = 1'b0;
    rx   = 1'b1;
    idle(3);
    check_all_zero("reset");
    rstN = 1'b1;
    idle(4 * CPB);

    // Good frame; cpuHold rises right after the sync byte
    got_q.delete();
    send_byte(8'hA5, 1'b1);
    check_flags("sync", 1'b1, 1'b0, 1'b0);
    fb = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(fb);
    ew = '{32'h0000_1234, 32'h0001_ABCD};
    check_writes("good", ew);
    check_flags("good", 1'b0, 1'b1, 1'b0);

    // Bad checksum, then recovery with a good frame
    fb = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_frame(fb);
    check_writes("badchk", ew);
    check_flags("badchk", 1'b1, 1'b0, 1'b1);
    fb = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(fb);
    check_writes("recover", ew);
    check_flags("recover", 1'b0, 1'b1, 1'b0);

    // Invalid lengths: zero and NumWords+1
    ew = '{};
    fb = '{8'hA5, 8'h00, 8'h00};
    send_frame(fb);
    check_writes("len0", ew);
    check_flags("len0", 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b1);
    check_flags("len_sync", 1'b1, 1'b0, 1'b0);
    fb = '{8'h10, 8'h01};
    send_frame(fb);
    check_writes("len4097", ew);
    check_flags("len4097", 1'b1, 1'b0, 1'b1);

    // Short low glitch inside a frame must not be taken as a byte
    send_byte(8'hA5, 1'b1);
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(2 * CPB);
    fb = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
    send_frame(fb);
    ew = '{32'h0000_BEEF};
    check_writes("glitch", ew);
    check_flags("glitch", 1'b0, 1'b1, 1'b0);

    // Framing error while waiting for a data high byte
    fb = '{8'hA5, 8'h00, 8'h01};
    send_frame(fb);
    send_byte(8'h12, 1'b0);
    idle(2 * CPB);
    ew = '{};
    check_writes("framing", ew);
    check_flags("framing", 1'b1, 1'b0, 1'b1);

    // Inter-byte timeout after LEN_HI
    fb = '{8'hA5, 8'h00};
    send_frame(fb);
    check_flags("to_pre", 1'b1, 1'b0, 1'b0);
    idle(TO + 1);
    check_writes("timeout", ew);
    check_flags("timeout", 1'b1, 1'b0, 1'b1);

    // Reset after one word, garbage afterwards, then a clean load
    fb = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
    send_frame(fb);
    ew = '{32'h0000_1234};
    check_writes("pre_rst", ew);
    chk("pre_rst_hold", 32'(cpuHold), 32'd1);
    rstN = 1'b0;
    #1;
    check_all_zero("async_rst");
    idle(3);
    rstN = 1'b1;
    idle(2 * CPB);
    fb = '{8'h00, 8'h55, 8'hFF, 8'h12};
    send_frame(fb);
    ew = '{};
    check_writes("garbage", ew);
    check_flags("garbage", 1'b0, 1'b0, 1'b0);
    fb = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
    send_frame(fb);
    ew = '{32'h0000_BEEF};
    check_writes("post_rst", ew);
    check_flags("post_rst", 1'b0, 1'b1, 1'b0);

    // Random frames against the frame-level model
    for (int t = 0; t < 6; t++) begin
      n       = int'($urandom_range(1, 5));
      corrupt = ($urandom_range(0, 2) == 0);
      xs      = 8'h00;
      fb      = '{8'hA5, 8'h00, 8'(n)};
      ew      = '{};
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        fb.push_back(w[15:8]);
        fb.push_back(w[7:0]);
        xs = xs ^ w[15:8] ^ w[7:0];
        ew.push_back({16'(i), w});
      end
      if (corrupt) xs = xs ^ 8'($urandom_range(1, 255));
      fb.push_back(xs);
      send_frame(fb);
      check_writes($sformatf("rand%0d", t), ew);
      check_flags($sformatf("rand%0d", t), corrupt, !corrupt, corrupt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
